// File: rtl/avl_rr_master_arbiter_pkg.sv
// Shared types and default widths for the round-robin Avalon-MM master arbiter.
// Also holds the index-width helper used by the arbiter and the selector.
package avl_arb_pkg;

    localparam int AVL_ADDR_W = 3;
    localparam int AVL_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    // Index width for an n-entry vector; never narrower than one bit.
    function automatic int rr_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/avl_rr_master_arbiter_if.sv
// Requester-side and Avalon-side signal bundle of the arbiter.
// The master modport is the arbiter's view; slave is the surrounding system's view.
interface avl_arb_if
    import avl_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = AVL_ADDR_W,
    parameter int DATA_W = AVL_DATA_W
) ();

    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        req_we;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        ack;
    logic [DATA_W-1:0]       rdata;
    logic [N_REQ-1:0]        grant;
    logic                    busy;

    logic                    avl_cs;
    logic                    avl_read;
    logic                    avl_write;
    logic                    avl_byte_en;
    logic [ADDR_W-1:0]       avl_addr;
    logic [DATA_W-1:0]       avl_writedata;
    logic [DATA_W-1:0]       avl_readdata;

    modport master (
        input  req, req_we, req_addr, req_wdata, avl_readdata,
        output ack, rdata, grant, busy,
        output avl_cs, avl_read, avl_write, avl_byte_en, avl_addr, avl_writedata
    );

    modport slave (
        output req, req_we, req_addr, req_wdata, avl_readdata,
        input  ack, rdata, grant, busy,
        input  avl_cs, avl_read, avl_write, avl_byte_en, avl_addr, avl_writedata
    );

endinterface

// File: rtl/avl_rr_master_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after last_i, wrapping.
// Purely combinational so it can be dropped into other arbiters unchanged.
module rr_pick
    import avl_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = rr_idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N_REQ-1:0] win_oh_o,
    output logic [IDX_W-1:0] win_idx_o,
    output logic             any_o
);

    // Walk last+1 .. last+N_REQ modulo N_REQ; the first hit wins.
    always_comb begin
        logic             found;
        logic             hit;
        logic [IDX_W-1:0] cand;
        win_oh_o  = '0;
        win_idx_o = '0;
        found     = 1'b0;
        hit       = 1'b0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand            = IDX_W'((int'(last_i) + k) % N_REQ);
            hit             = req_i[cand] & ~found;
            win_oh_o[cand]  = win_oh_o[cand] | hit;
            win_idx_o       = hit ? cand : win_idx_o;
            found           = found | hit;
        end
        any_o = found;
    end

endmodule

// File: rtl/avl_rr_master_arbiter.sv
// Round-robin master arbiter sharing one Avalon-MM register slave between N_REQ
// requesters: one strobe per transaction, read data captured, one-cycle ACK.
module avl_rr_master_arbiter
    import avl_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = AVL_ADDR_W,
    parameter int DATA_W = AVL_DATA_W
) (
    input  logic      clk,
    input  logic      rst,
    avl_arb_if.master arb_if
);

    localparam int IDX_W = rr_idx_w(N_REQ);

    logic [N_REQ-1:0]  win_oh_s;
    logic [IDX_W-1:0]  win_idx_s;
    logic              win_any_s;
    logic              start_s;

    logic [ADDR_W-1:0] req_addr_s  [N_REQ];
    logic [DATA_W-1:0] req_wdata_s [N_REQ];
    logic              cmd_we_d;
    logic [ADDR_W-1:0] cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_d;

    arb_state_t        state_q;
    logic [IDX_W-1:0]  last_q;
    logic [IDX_W-1:0]  owner_q;
    logic              we_q;
    logic [N_REQ-1:0]  grant_q;
    logic [N_REQ-1:0]  ack_q;
    logic [DATA_W-1:0] rdata_q;
    logic              busy_q;
    logic              cs_q;
    logic              rd_q;
    logic              wr_q;
    logic              be_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i     (arb_if.req),
        .last_i    (last_q),
        .win_oh_o  (win_oh_s),
        .win_idx_o (win_idx_s),
        .any_o     (win_any_s)
    );

    // Unpack the per-requester command fields.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_addr_s[i]  = arb_if.req_addr[i*ADDR_W +: ADDR_W];
            req_wdata_s[i] = arb_if.req_wdata[i*DATA_W +: DATA_W];
        end
    end

    // The ACK cycle is never an arbitration cycle, so a REQ still high while
    // its ACK is visible is not mistaken for a new request.
    always_comb begin
        cmd_we_d    = arb_if.req_we[win_idx_s];
        cmd_addr_d  = req_addr_s[win_idx_s];
        cmd_wdata_d = req_wdata_s[win_idx_s];
        start_s     = (state_q == IDLE) && (ack_q == '0) && win_any_s;
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= IDX_W'(N_REQ - 1);
            owner_q <= '0;
            we_q    <= 1'b0;
            grant_q <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            cs_q    <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            be_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            ack_q <= '0;
            cs_q  <= 1'b0;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            be_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_s) begin
                        owner_q <= win_idx_s;
                        grant_q <= win_oh_s;
                        we_q    <= cmd_we_d;
                        busy_q  <= 1'b1;
                        cs_q    <= 1'b1;
                        be_q    <= 1'b1;
                        wr_q    <= cmd_we_d;
                        rd_q    <= ~cmd_we_d;
                        addr_q  <= cmd_addr_d;
                        wdata_q <= cmd_wdata_d;
                        state_q <= ISSUE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
                    state_q <= we_q ? RESP : WAIT_RD;
                end
                WAIT_RD: begin
                    rdata_q <= arb_if.avl_readdata;
                    state_q <= RESP;
                end
                RESP: begin
                    ack_q   <= grant_q;
                    last_q  <= owner_q;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign arb_if.ack           = ack_q;
    assign arb_if.rdata         = rdata_q;
    assign arb_if.grant         = grant_q;
    assign arb_if.busy          = busy_q;
    assign arb_if.avl_cs        = cs_q;
    assign arb_if.avl_read      = rd_q;
    assign arb_if.avl_write     = wr_q;
    assign arb_if.avl_byte_en   = be_q;
    assign arb_if.avl_addr      = addr_q;
    assign arb_if.avl_writedata = wdata_q;

endmodule

// File: tb/tb_avl_rr_master_arbiter.sv
// Bench for avl_rr_master_arbiter: 2- and 4-requester instances, each against
// an 8x8 register slave and a transaction-timeline reference model.
module tb_avl_rr_master_arbiter;
    import avl_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    avl_arb_if #(.N_REQ(2)) b2 ();
    avl_arb_if #(.N_REQ(4)) b4 ();

    avl_rr_master_arbiter #(.N_REQ(2)) dut2 (.clk(clk), .rst(rst), .arb_if(b2));
    avl_rr_master_arbiter #(.N_REQ(4)) dut4 (.clk(clk), .rst(rst), .arb_if(b4));

    logic [7:0] smem2 [0:7];
    logic [7:0] smem4 [0:7];

    // Register slaves: registered read data, memory cleared while in reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                smem2[i] <= 8'h00;
                smem4[i] <= 8'h00;
            end
            b2.avl_readdata <= 8'h00;
            b4.avl_readdata <= 8'h00;
        end else begin
            if (b2.avl_cs && b2.avl_write) smem2[b2.avl_addr] <= b2.avl_writedata;
            if (b4.avl_cs && b4.avl_write) smem4[b4.avl_addr] <= b4.avl_writedata;
            b2.avl_readdata <= smem2[b2.avl_addr];
            b4.avl_readdata <= smem4[b4.avl_addr];
        end
    end

    int tests = 0;
    int fails = 0;

    // Reference model: m_phase counts cycles since the winning sample (0 = free);
    // strobe at 1, ACK at m_len (3 write, 4 read), then one cycle with no sampling.
    int         m_phase [0:1];
    int         m_len   [0:1];
    int         m_owner [0:1];
    int         m_last  [0:1];
    logic       m_we    [0:1];
    logic [2:0] m_addr  [0:1];
    logic [7:0] m_wdata [0:1];
    logic [7:0] m_rdata [0:1];
    logic [7:0] m_mem   [0:1][0:7];

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nreq(input int u);
        return (u == 0) ? 2 : 4;
    endfunction

    function automatic int pick(input int n, input logic [3:0] r, input int last);
        for (int k = 1; k <= n; k++) begin
            if (r[(last + k) % n]) return (last + k) % n;
        end
        return 0;
    endfunction

    function automatic logic [3:0] o_ack(input int u);
        return (u == 0) ? {2'b00, b2.ack} : b4.ack;
    endfunction

    function automatic logic [3:0] o_grant(input int u);
        return (u == 0) ? {2'b00, b2.grant} : b4.grant;
    endfunction

    function automatic logic o_cs(input int u);
        return (u == 0) ? b2.avl_cs : b4.avl_cs;
    endfunction

    task automatic mreset();
        for (int u = 0; u < 2; u++) begin
            m_phase[u] = 0;
            m_len[u]   = 3;
            m_owner[u] = 0;
            m_last[u]  = nreq(u) - 1;
            m_rdata[u] = 8'h00;
            for (int i = 0; i < 8; i++) m_mem[u][i] = 8'h00;
        end
    endtask

    task automatic mupd(input int u);
        logic [3:0]  r;
        logic [3:0]  w;
        logic [11:0] a;
        logic [31:0] d;
        if (u == 0) begin
            r = {2'b00, b2.req}; w = {2'b00, b2.req_we};
            a = {6'b0, b2.req_addr}; d = {16'h0, b2.req_wdata};
        end else begin
            r = b4.req; w = b4.req_we; a = b4.req_addr; d = b4.req_wdata;
        end
        if (m_phase[u] == 0) begin
            if (r != 4'b0000) begin
                m_owner[u] = pick(nreq(u), r, m_last[u]);
                m_we[u]    = w[m_owner[u]];
                m_addr[u]  = a[m_owner[u]*3 +: 3];
                m_wdata[u] = d[m_owner[u]*8 +: 8];
                m_len[u]   = m_we[u] ? 3 : 4;
                m_phase[u] = 1;
            end
        end else if (m_phase[u] == m_len[u]) begin
            m_phase[u] = 0;
        end else begin
            if (m_phase[u] == 1 && m_we[u]) m_mem[u][m_addr[u]] = m_wdata[u];
            if (m_phase[u] == 2 && !m_we[u]) m_rdata[u] = m_mem[u][m_addr[u]];
            m_phase[u]++;
            if (m_phase[u] == m_len[u]) m_last[u] = m_owner[u];
        end
    endtask

    task automatic chk(input int u);
        logic       eb, es;
        logic [3:0] eg, ea;
        logic [12:0] obs;
        logic [7:0] ordata;
        logic [2:0] oaddr;
        logic [7:0] owd;
        eb = (m_phase[u] >= 1) && (m_phase[u] < m_len[u]);
        es = (m_phase[u] == 1);
        eg = eb ? (4'b0001 << m_owner[u]) : 4'b0000;
        ea = (m_phase[u] != 0 && m_phase[u] == m_len[u]) ? (4'b0001 << m_owner[u]) : 4'b0000;
        if (u == 0) begin
            obs = {2'b00, b2.grant, 2'b00, b2.ack, b2.busy, b2.avl_cs, b2.avl_read,
                   b2.avl_write, b2.avl_byte_en};
            ordata = b2.rdata; oaddr = b2.avl_addr; owd = b2.avl_writedata;
        end else begin
            obs = {b4.grant, b4.ack, b4.busy, b4.avl_cs, b4.avl_read, b4.avl_write,
                   b4.avl_byte_en};
            ordata = b4.rdata; oaddr = b4.avl_addr; owd = b4.avl_writedata;
        end
        expect_eq((u == 0) ? "ctl_n2" : "ctl_n4", 32'(obs),
                  32'({eg, ea, eb, es, es & ~m_we[u], es & m_we[u], es}));
        expect_eq((u == 0) ? "rdata_n2" : "rdata_n4", 32'(ordata), 32'(m_rdata[u]));
        if (es) begin
            expect_eq((u == 0) ? "addr_n2" : "addr_n4", 32'(oaddr), 32'(m_addr[u]));
            if (m_we[u]) expect_eq((u == 0) ? "wdata_n2" : "wdata_n4", 32'(owd), 32'(m_wdata[u]));
        end
    endtask

    task automatic step();
        if (!rst) begin
            mupd(0);
            mupd(1);
        end
        @(posedge clk);
        #1;
        chk(0);
        chk(1);
    endtask

    task automatic run_to_ack(input int u, input logic [3:0] mask, input int maxc,
                              output int lat, output int nstb);
        lat  = -1;
        nstb = 0;
        for (int c = 1; c <= maxc; c++) begin
            step();
            if (o_cs(u)) nstb++;
            if ((o_ack(u) & mask) != 4'b0000) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic drive_rand(input int u);
        logic [3:0]  r, w, ak;
        logic [11:0] a;
        logic [31:0] d;
        if (u == 0) begin
            r = {2'b00, b2.req}; w = {2'b00, b2.req_we};
            a = {6'b0, b2.req_addr}; d = {16'h0, b2.req_wdata};
        end else begin
            r = b4.req; w = b4.req_we; a = b4.req_addr; d = b4.req_wdata;
        end
        ak = o_ack(u);
        for (int i = 0; i < nreq(u); i++) begin
            if (r[i] && ak[i]) begin
                if ($urandom_range(1, 0) == 0) begin
                    r[i] = 1'b0;
                end else begin
                    w[i] = 1'($urandom_range(1, 0));
                    a[i*3 +: 3] = 3'($urandom_range(7, 0));
                    d[i*8 +: 8] = 8'($urandom_range(255, 0));
                end
            end else if (r[i]) begin
                if ($urandom_range(7, 0) == 0) r[i] = 1'b0;
            end else if ($urandom_range(2, 0) == 0) begin
                r[i] = 1'b1;
                w[i] = 1'($urandom_range(1, 0));
                a[i*3 +: 3] = 3'($urandom_range(7, 0));
                d[i*8 +: 8] = 8'($urandom_range(255, 0));
            end
        end
        if (u == 0) begin
            b2.req = r[1:0]; b2.req_we = w[1:0]; b2.req_addr = a[5:0]; b2.req_wdata = d[15:0];
        end else begin
            b4.req = r; b4.req_we = w; b4.req_addr = a; b4.req_wdata = d;
        end
    endtask

    initial begin
        int         lat, nstb, nack, prev_stb, min_gap;
        logic       saw_g0;
        logic [3:0] av;

        rst = 1'b1;
        b2.req = '0; b2.req_we = '0; b2.req_addr = '0; b2.req_wdata = '0;
        b4.req = '0; b4.req_we = '0; b4.req_addr = '0; b4.req_wdata = '0;
        mreset();
        step();
        step();
        rst = 1'b0;

        // 1: requester 0 writes A5 to address 5.
        b2.req_we = 2'b01; b2.req_addr = {3'd0, 3'd5}; b2.req_wdata = {8'h00, 8'hA5};
        b2.req = 2'b01;
        run_to_ack(0, 4'b0001, 10, lat, nstb);
        expect_eq("t1_latency", 32'(lat), 32'd3);
        expect_eq("t1_strobes", 32'(nstb), 32'd1);
        b2.req = 2'b00;
        expect_eq("t1_slave_mem5", 32'(smem2[5]), 32'hA5);
        step();

        // 2: requester 1 reads address 5, then a write must leave RDATA alone.
        b2.req_we = 2'b00; b2.req_addr = {3'd5, 3'd0}; b2.req = 2'b10;
        run_to_ack(0, 4'b0010, 10, lat, nstb);
        expect_eq("t2_latency", 32'(lat), 32'd4);
        expect_eq("t2_strobes", 32'(nstb), 32'd1);
        expect_eq("t2_rdata", 32'(b2.rdata), 32'hA5);
        b2.req = 2'b00;
        step();
        b2.req_we = 2'b10; b2.req_addr = {3'd2, 3'd0}; b2.req_wdata = {8'h3C, 8'h00};
        b2.req = 2'b10;
        run_to_ack(0, 4'b0010, 10, lat, nstb);
        expect_eq("t2_wr_latency", 32'(lat), 32'd3);
        expect_eq("t2_rdata_kept", 32'(b2.rdata), 32'hA5);
        b2.req = 2'b00;
        step();

        // 3: both hold REQ with writes; grants must alternate 0,1,0,1.
        b2.req_we = 2'b11; b2.req_addr = {3'd2, 3'd1}; b2.req_wdata = {8'h22, 8'h11};
        b2.req = 2'b11;
        nack = 0; prev_stb = -100; min_gap = 100;
        for (int c = 0; c < 40 && nack < 4; c++) begin
            step();
            if (o_cs(0)) begin
                if (c - prev_stb < min_gap) min_gap = c - prev_stb;
                prev_stb = c;
            end
            av = o_ack(0);
            if (av != 4'b0000) begin
                expect_eq("t3_ack_order", 32'(av), 32'(4'b0001 << (nack % 2)));
                nack++;
            end
        end
        expect_eq("t3_ack_count", 32'(nack), 32'd4);
        expect_eq("t3_strobe_gap", 32'(min_gap >= 4), 32'd1);
        b2.req = 2'b00;
        step();

        // 4a: requester 0 reads address 1 and drops REQ the cycle after GRANT.
        b2.req_we = 2'b00; b2.req_addr = {3'd0, 3'd1}; b2.req = 2'b01;
        for (int c = 0; c < 5; c++) begin
            step();
            if (o_grant(0)[0]) break;
        end
        expect_eq("t4_granted", 32'(o_grant(0)), 32'h1);
        step();
        b2.req = 2'b00;
        run_to_ack(0, 4'b0001, 10, lat, nstb);
        expect_eq("t4_ack_after_drop", 32'(lat > 0), 32'd1);
        expect_eq("t4_rdata", 32'(b2.rdata), 32'h11);
        step();

        // 4b: requester 0 pulses REQ only while requester 1 owns the bus.
        b2.req_we = 2'b10; b2.req_addr = {3'd3, 3'd0}; b2.req_wdata = {8'h33, 8'h00};
        b2.req = 2'b10;
        step();
        b2.req = 2'b11;
        step();
        b2.req = 2'b10;
        saw_g0 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            saw_g0 = saw_g0 | o_grant(0)[0];
            if (o_ack(0)[1]) b2.req = 2'b00;
        end
        expect_eq("t4_dropped_never_granted", 32'(saw_g0), 32'd0);

        // 5: reset during WAIT_RD aborts the read; afterwards requester 0 wins first.
        b2.req_we = 2'b00; b2.req_addr = {3'd0, 3'd2}; b2.req = 2'b01;
        step();
        step();
        expect_eq("t5_in_wait_rd", 32'(m_phase[0]), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        mreset();
        chk(0);
        chk(1);
        expect_eq("t5_rst_addr", 32'(b2.avl_addr), 32'd0);
        step();
        b2.req = 2'b00;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) step();
        b2.req_we = 2'b11; b2.req_addr = {3'd6, 3'd7}; b2.req_wdata = {8'h66, 8'h77};
        b2.req = 2'b11;
        step();
        expect_eq("t5_first_grant", 32'(o_grant(0)), 32'h1);
        run_to_ack(0, 4'b0001, 10, lat, nstb);
        b2.req = 2'b10;
        run_to_ack(0, 4'b0010, 12, lat, nstb);
        expect_eq("t5_second_ack", 32'(lat > 0), 32'd1);
        b2.req = 2'b00;
        step();

        // 6: four requesters held high must rotate 0,1,2,3,0,1,2,3.
        b4.req_we = 4'b1111; b4.req_addr = {3'd3, 3'd2, 3'd1, 3'd0};
        b4.req_wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        b4.req = 4'b1111;
        nack = 0;
        for (int c = 0; c < 60 && nack < 8; c++) begin
            step();
            av = o_ack(1);
            if (av != 4'b0000) begin
                expect_eq("t6_rotation", 32'(av), 32'(4'b0001 << (nack % 4)));
                nack++;
            end
        end
        expect_eq("t6_ack_count", 32'(nack), 32'd8);
        b4.req = 4'b0000;
        step();

        // Random traffic on both instances against the model.
        for (int c = 0; c < 400; c++) begin
            drive_rand(0);
            drive_rand(1);
            step();
        end
        b2.req = '0;
        b4.req = '0;
        for (int c = 0; c < 6; c++) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/avl_rr_master_arbiter.md
Name: avl_rr_master_arbiter

Overview:
- Shares the single 8-byte Avalon-MM register slave (8 x 8-bit registers, LED export) between N_REQ on-chip requesters, such as the NIOS bridge and hardware engines.
- Arbitrates round-robin, latches the winner's command, and issues exactly one Avalon read or write strobe.
- For reads, captures the slave's registered read data (1-cycle latency) and returns an ACK pulse to the winner.
- Sits between the requesters and the slave's AVL_* pins.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- ADDR_W, 3, Avalon word address width.
- DATA_W, 8, Avalon data width.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- REQ  in  N_REQ  per-requester request level.
- REQ_WE  in  N_REQ  1 = write, 0 = read.
- REQ_ADDR  in  N_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- REQ_WDATA  in  N_REQ*DATA_W  packed write data.
- ACK  out  N_REQ  one-hot, 1-cycle completion pulse.
- RDATA  out  DATA_W  read data; valid in the ACK cycle, held until next read capture.
- GRANT  out  N_REQ  one-hot current owner; high from ISSUE through RESP.
- BUSY  out  1  FSM not in IDLE.
- AVL_CS, AVL_READ, AVL_WRITE, AVL_BYTE_EN  out  1 each  slave strobes.
- AVL_ADDR  out  ADDR_W  slave address.
- AVL_WRITEDATA  out  DATA_W  slave write data.
- AVL_READDATA  in  DATA_W  slave read data; registered by the slave.

Behaviour:
- Clocking and reset: one clock, CLK. RESET is asynchronous and active-high. All outputs are registered.
- Reset values: every output 0; FSM = IDLE; round-robin pointer LAST = N_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE:
  - If any REQ bit is high, pick the first requester searching LAST+1, LAST+2, … modulo N_REQ.
  - Latch that requester's WE, ADDR and WDATA; set GRANT one-hot; go to ISSUE.
  - If no REQ bit is high, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - AVL_CS = 1, AVL_BYTE_EN = 1, AVL_ADDR/AVL_WRITEDATA = latched values.
  - AVL_WRITE = WE, AVL_READ = !WE.
  - Next state: write -> RESP; read -> WAIT_RD.
- WAIT_RD (1 cycle): strobes are 0; capture AVL_READDATA into the RDATA register at the end of the cycle; go to RESP.
- RESP (1 cycle): ACK[winner] = 1; LAST <= winner; GRANT clears on exit; go to IDLE.
- Strobe rule: all AVL_* strobes are 0 outside ISSUE. AVL_ADDR and AVL_WRITEDATA may hold their last value.
- Latency, measured from the IDLE cycle in which REQ is sampled:
  - Write: ACK at +3 cycles.
  - Read: ACK at +4 cycles, with RDATA valid.
  - Throughput: one write per 4 cycles; one read per 5 cycles.
- Requester contract:
  - Hold the command stable while REQ is high until ACK.
  - Commands are sampled only in IDLE.
  - Keeping REQ high after ACK is a new request. It re-arbitrates normally, so a competing requester wins next.
- Dropping requests:
  - REQ dropped before grant: no transaction is issued.
  - REQ dropped after grant: the transaction completes and ACK still pulses.
- Boundaries:
  - Simultaneous requests: served in strict rotation, with no starvation (bounded wait of N_REQ-1 transactions).
  - Single requester: always granted, regardless of LAST.
  - RDATA changes only on a read capture; a write leaves it unchanged.
  - Address space is 0..2^ADDR_W-1, all valid; no decode errors.
- Reset mid-operation: all outputs return to 0 immediately (async). An in-flight strobe is aborted; no ACK is ever issued for it. LAST returns to N_REQ-1.

Decomposition:
- Shared package avl_arb_pkg:
  - State enum arb_state_t {IDLE, ISSUE, WAIT_RD, RESP}.
  - Default widths AVL_ADDR_W = 3, AVL_DATA_W = 8.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: REQ vector and LAST index.
  - Outputs: one-hot winner and its index.
  - Reusable by later arbiters.
- FSM, command latch and RDATA capture live in the top module.

Test Plan:
1. Reset, then REQ = 01, WE = 1, ADDR = 5, WDATA = 8'hA5 -> AVL_WRITE high for exactly one cycle with AVL_ADDR = 5, AVL_WRITEDATA = 8'hA5, AVL_CS = 1; ACK = 01 three cycles after REQ is sampled; slave mem[5] = 8'hA5.
2. After test 1, requester 1 reads address 5 -> AVL_READ pulses 1 cycle; ACK = 10 at +4 cycles; RDATA = 8'hA5; RDATA unchanged by a following write.
3. Both requesters hold REQ continuously, writes to addresses 1 and 2 -> grants alternate 0, 1, 0, 1 (requester 0 first after reset); ACKs alternate; no two strobes closer than 4 cycles.
4. Requester 0 raises REQ for a read, then drops it in the cycle after GRANT -> read still completes; ACK[0] pulses; RDATA = stored value. Separately, REQ dropped while another requester owns the bus -> never granted.
5. Assert RESET during WAIT_RD -> all outputs 0 asynchronously; no ACK; after release, REQ = 11 grants requester 0 first.
6. N_REQ = 4 build, REQ = 1111 for 8 transactions -> grant order 0, 1, 2, 3, 0, 1, 2, 3.
